// File: rtl/neuro_pkg.sv
// Shared sizing, accumulator width, FSM state type and the power-on neuron
// pattern for the Hopfield sweep controller.
package neuro_pkg;

  localparam int N_DEF  = 25;
  localparam int WW_DEF = 8;
  localparam int AW_DEF = 10;

  // Five guard bits hold 25 products of magnitude up to 128, including the
  // negation of the most negative weight, without wrapping.
  function automatic int acc_width(input int ww);
    return ww + 5;
  endfunction

  localparam int ACC_W = acc_width(WW_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } sweep_state_t;

  localparam logic [N_DEF-1:0] DEF_PATTERN = 25'b0111010011100100001001110;

endpackage

// File: rtl/neuro_sweep_ctrl_if.sv
// Weight-loader write handshake plus synchronous weight-RAM bus. The master
// side is the sweep controller; the slave side is the loader and the RAM.
interface neuro_sweep_ctrl_if
  import neuro_pkg::*;
#(
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          wr_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
    input  mem_rdata, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
    output mem_rdata, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/neuro_mac.sv
// Sign-select multiply-accumulate for one neuron's weighted input sum.
// A source bit of 1 adds the weight, a source bit of 0 subtracts it.
module neuro_mac
  import neuro_pkg::*;
#(
  parameter int WW   = WW_DEF,
  parameter int ACCW = acc_width(WW_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   src,
  input  logic signed [WW-1:0]   w,
  output logic signed [ACCW-1:0] sum
);

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] wide;
  logic signed [ACCW-1:0] term;

  // Widen before negating so that -(-128) is representable.
  always_comb begin
    wide = ACCW'(w);
    term = src ? wide : -wide;
    sum  = acc + term;
  end

  // Running sum; clear wins over accumulate so the decide cycle can reset it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/neuro_sweep_ctrl.sv
// Hopfield update sweep controller: streams the N x N weight matrix out of a
// synchronous RAM, updates every neuron once per sweep (in place or from a
// start-time snapshot) and arbitrates RAM access with the weight loader.
module neuro_sweep_ctrl
  import neuro_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sync_mode,
  input  logic                init_load,
  input  logic [N-1:0]        init_pattern,
  neuro_sweep_ctrl_if.master  bus,
  output logic [N-1:0]        neuros,
  output logic                busy,
  output logic                done,
  output logic                converged
);

  localparam int CW   = $clog2(N + 1);
  localparam int ACCW = acc_width(WW);
  localparam logic [CW-1:0] LAST_K   = CW'(N - 1);
  localparam logic [CW-1:0] DECIDE_M = CW'(N);

  sweep_state_t state, state_nxt;

  logic [CW-1:0] k;
  logic [CW-1:0] m;
  logic [CW-1:0] src_idx;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  snap;
  logic          mode;
  logic          pend;
  logic          changed;
  logic          wr_ack_q;

  logic accept;
  logic issue;
  logic absorb;
  logic decide;
  logic last_neuron;
  logic writing;
  logic src_bit;
  logic new_bit;
  logic flip;
  logic signed [ACCW-1:0] sum;

  // Per-cycle control decodes; m = N is the extra cycle that absorbs the last
  // read and decides, and rdata in cycle m belongs to source neuron m-1.
  always_comb begin
    writing     = rst && (state == IDLE) && bus.wr_req && !wr_ack_q;
    accept      = (state == IDLE) && (start || pend) && !bus.wr_req;
    issue       = (state == SWEEP) && (m < DECIDE_M);
    absorb      = (state == SWEEP) && (m != '0);
    decide      = (state == SWEEP) && (m == DECIDE_M);
    last_neuron = (k == LAST_K);
    src_idx     = '0;
    if (m != '0) begin
      src_idx = m - CW'(1);
    end
    src_bit = mode ? snap[src_idx] : neuros[src_idx];
    new_bit = !sum[ACCW-1] && (sum != '0);
    flip    = new_bit != neuros[k];
  end

  neuro_mac #(
    .WW  (WW),
    .ACCW(ACCW)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(accept || decide),
    .en (absorb && !decide),
    .src(src_bit),
    .w  ($signed(bus.mem_rdata)),
    .sum(sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one sweep per accepted start, then a single FINISH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SWEEP;
      SWEEP:   if (decide && last_neuron) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and RAM bus steering; reads only in SWEEP, writes only in IDLE.
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == FINISH);
    bus.mem_rd    = issue;
    bus.mem_we    = writing;
    bus.mem_addr  = issue ? rd_addr : bus.wr_addr;
    bus.mem_wdata = bus.wr_data;
    bus.wr_ack    = wr_ack_q;
  end

  // Neuron/source counters; the read address simply runs 0..N*N-1 because
  // row k of the matrix directly follows row k-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= '0;
      m       <= '0;
      rd_addr <= '0;
    end else if (accept) begin
      k       <= '0;
      m       <= '0;
      rd_addr <= '0;
    end else if (state == SWEEP) begin
      if (issue) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if (decide) begin
        m <= '0;
        k <= last_neuron ? '0 : k + CW'(1);
      end else begin
        m <= m + CW'(1);
      end
    end
  end

  // Neuron state: preload while idle, otherwise one neuron per decide cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neuros <= N'(DEF_PATTERN);
    end else if ((state == IDLE) && init_load) begin
      neuros <= init_pattern;
    end else if (decide) begin
      neuros[k] <= new_bit;
    end
  end

  // Snapshot and mode capture at accept; a same-cycle preload feeds the snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
      mode <= 1'b0;
    end else if (accept) begin
      snap <= init_load ? init_pattern : neuros;
      mode <= sync_mode;
    end
  end

  // Start deferred behind a loader write that arrived in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= 1'b0;
    end else if ((state == IDLE) && start && bus.wr_req) begin
      pend <= 1'b1;
    end
  end

  // Change tracking; converged is settled on entry to FINISH so it is valid with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed   <= 1'b0;
      converged <= 1'b0;
    end else if (accept) begin
      changed   <= 1'b0;
      converged <= 1'b0;
    end else if (decide) begin
      changed <= changed || flip;
      if (last_neuron) begin
        converged <= !(changed || flip);
      end
    end
  end

  // Loader acknowledge one cycle after the write reaches the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= writing;
    end
  end

endmodule

// File: tb/tb_neuro_sweep_ctrl.sv
// Directed self-checking bench for neuro_sweep_ctrl with a behavioural
// synchronous weight RAM and a small Hopfield reference sweep.
module tb_neuro_sweep_ctrl;

  localparam logic [24:0] DEF_PAT = 25'b0111010011100100001001110;
  localparam logic [24:0] ALL_ONE = 25'h1FFFFFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sync_mode;
  logic        init_load;
  logic [24:0] init_pattern;
  logic [24:0] neuros;
  logic        busy;
  logic        done;
  logic        converged;

  neuro_sweep_ctrl_if bus ();

  neuro_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sync_mode   (sync_mode),
    .init_load   (init_load),
    .init_pattern(init_pattern),
    .bus         (bus),
    .neuros      (neuros),
    .busy        (busy),
    .done        (done),
    .converged   (converged)
  );

  int checks = 0;
  int errors = 0;

  logic signed [7:0] ram [0:624];
  logic              fill_go;
  int                fill_kind;

  int   lat;
  int   rd_cnt;
  int   addr_err;
  int   excl_err;
  int   busy_we;
  logic busy_first;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] weight_of(input int kind, input int i);
    case (kind)
      1:       return (i / 25 == i % 25) ? 8'h01 : 8'h00;
      2:       return 8'h7F;
      3:       return 8'h80;
      4:       return (i == 0) ? 8'hF6 : ((i == 25 || i == 51) ? 8'h0A : 8'h00);
      default: return 8'h00;
    endcase
  endfunction

  // Weight RAM: one-cycle read latency, plus a bench-side bulk fill.
  always @(posedge clk) begin
    if (fill_go) begin
      for (int i = 0; i < 625; i++) ram[i] <= weight_of(fill_kind, i);
    end else if (bus.mem_we && bus.mem_addr < 10'd625) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd && bus.mem_addr < 10'd625) bus.mem_rdata <= ram[bus.mem_addr];
  end

  function automatic logic [24:0] ref_sweep(input logic [24:0] init, input logic smode);
    logic [24:0] cur;
    int sum;
    int w;
    cur = init;
    for (int k = 0; k < 25; k++) begin
      sum = 0;
      for (int m = 0; m < 25; m++) begin
        w = int'(ram[k * 25 + m]);
        if (smode ? init[m] : cur[m]) sum += w;
        else sum -= w;
      end
      cur[k] = (sum > 0);
    end
    return cur;
  endfunction

  task automatic load_weights(input int kind);
    @(negedge clk);
    fill_kind = kind;
    fill_go   = 1'b1;
    @(negedge clk);
    fill_go   = 1'b0;
  endtask

  task automatic load_pattern(input logic [24:0] p);
    @(negedge clk);
    init_load    = 1'b1;
    init_pattern = p;
    @(negedge clk);
    init_load    = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Observe a running sweep from the cycle after accept until done (bounded).
  task automatic wait_done(input int wr_at, output int o_lat, output int o_rd,
                           output int o_aerr, output int o_excl, output int o_bwe,
                           output logic o_busy1);
    int exp_addr;
    o_lat = -1; o_rd = 0; o_aerr = 0; o_excl = 0; o_bwe = 0; o_busy1 = 1'b0;
    exp_addr = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 1) o_busy1 = busy;
      if (bus.mem_rd && bus.mem_we) o_excl++;
      if (busy && (bus.mem_we || bus.wr_ack)) o_bwe++;
      if (bus.mem_rd) begin
        if (int'(bus.mem_addr) != exp_addr) o_aerr++;
        exp_addr++;
        o_rd++;
      end
      if (n == wr_at) bus.wr_req = 1'b1;
      if (done) begin
        o_lat = n;
        break;
      end
    end
  endtask

  task automatic run_sweep(input logic smode, input int wr_at);
    @(negedge clk);
    start     = 1'b1;
    sync_mode = smode;
    @(posedge clk);
    #1 start  = 1'b0;
    wait_done(wr_at, lat, rd_cnt, addr_err, excl_err, busy_we, busy_first);
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'd5;
    bus.wr_data = 8'h11;
    repeat (2) @(negedge clk);
    checks++; if (neuros !== DEF_PAT) begin errors++; $display("[TB] FAIL reset_neuros: got %h expected %h", neuros, DEF_PAT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL reset_converged: got %b expected 0", converged); end
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ack: got %b expected 0", bus.wr_ack); end
    bus.wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || neuros !== DEF_PAT) begin errors++; $display("[TB] FAIL post_reset_idle: busy %b neuros %h expected 0 %h", busy, neuros, DEF_PAT); end
  endtask

  task automatic test_zero_weights();
    load_weights(0);
    run_sweep(1'b0, 0);
    checks++; if (lat !== 651) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 651", lat); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy_rise: got %b expected 1", busy_first); end
    checks++; if (rd_cnt !== 625 || addr_err !== 0) begin errors++; $display("[TB] FAIL zero_read_seq: reads %0d addr_err %0d expected 625 0", rd_cnt, addr_err); end
    checks++; if (excl_err !== 0) begin errors++; $display("[TB] FAIL zero_rd_we_excl: got %0d expected 0", excl_err); end
    checks++; if (neuros !== 25'd0) begin errors++; $display("[TB] FAIL zero_neuros: got %h expected 0", neuros); end
    checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL zero_converged: got %b expected 0", converged); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_diag();
    pulse_reset();
    load_weights(1);
    run_sweep(1'b0, 0);
    checks++; if (lat !== 651) begin errors++; $display("[TB] FAIL diag_latency: got %0d expected 651", lat); end
    checks++; if (neuros !== DEF_PAT) begin errors++; $display("[TB] FAIL diag_neuros: got %h expected %h", neuros, DEF_PAT); end
    checks++; if (converged !== 1'b1) begin errors++; $display("[TB] FAIL diag_converged: got %b expected 1", converged); end
  endtask

  task automatic test_saturate();
    load_weights(2);
    load_pattern(ALL_ONE);
    checks++; if (neuros !== ALL_ONE) begin errors++; $display("[TB] FAIL init_load: got %h expected %h", neuros, ALL_ONE); end
    run_sweep(1'b0, 0);
    checks++; if (neuros !== ALL_ONE) begin errors++; $display("[TB] FAIL pos_max_neuros: got %h expected %h", neuros, ALL_ONE); end
    checks++; if (converged !== 1'b1) begin errors++; $display("[TB] FAIL pos_max_converged: got %b expected 1", converged); end
    load_weights(3);
    load_pattern(25'd0);
    run_sweep(1'b1, 0);
    checks++; if (neuros !== ALL_ONE) begin errors++; $display("[TB] FAIL neg_max_sync: got %h expected %h", neuros, ALL_ONE); end
    checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL neg_max_converged: got %b expected 0", converged); end
    load_pattern(25'd0);
    run_sweep(1'b0, 0);
    checks++; if (neuros !== 25'h0001FFF) begin errors++; $display("[TB] FAIL neg_max_async: got %h expected 0001fff", neuros); end
  endtask

  task automatic test_chain();
    logic [24:0] exp_v;
    load_weights(4);
    load_pattern(25'd0);
    exp_v = ref_sweep(25'd0, 1'b0);
    run_sweep(1'b0, 0);
    checks++; if (neuros !== exp_v) begin errors++; $display("[TB] FAIL chain_async: got %h expected %h", neuros, exp_v); end
    checks++; if (converged !== 1'b0) begin errors++; $display("[TB] FAIL chain_converged: got %b expected 0", converged); end
    load_pattern(25'd0);
    exp_v = ref_sweep(25'd0, 1'b1);
    run_sweep(1'b1, 0);
    checks++; if (neuros !== exp_v) begin errors++; $display("[TB] FAIL chain_sync: got %h expected %h", neuros, exp_v); end
  endtask

  task automatic test_write_during_sweep();
    load_weights(0);
    load_pattern(25'h0000155);
    bus.wr_addr = 10'd7;
    bus.wr_data = 8'h55;
    run_sweep(1'b0, 100);
    checks++; if (lat !== 651) begin errors++; $display("[TB] FAIL wr_sweep_latency: got %0d expected 651", lat); end
    checks++; if (busy_we !== 0) begin errors++; $display("[TB] FAIL wr_while_busy: got %0d expected 0", busy_we); end
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd7 || bus.mem_wdata !== 8'h55) begin
      errors++; $display("[TB] FAIL wr_idle_fwd: we %b addr %0d data %h expected 1 7 55", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk);
    checks++; if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack: ack %b we %b expected 1 0", bus.wr_ack, bus.mem_we); end
    checks++; if (ram[7] !== 8'sh55) begin errors++; $display("[TB] FAIL wr_ram: got %h expected 55", ram[7]); end
    bus.wr_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack_drop: got %b expected 0", bus.wr_ack); end
  endtask

  task automatic test_start_with_write();
    @(negedge clk);
    start       = 1'b1;
    sync_mode   = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'd3;
    bus.wr_data = 8'hFB;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL sw_write_first: we %b rd %b expected 1 0", bus.mem_we, bus.mem_rd); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (bus.wr_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sw_pending: ack %b busy %b expected 1 0", bus.wr_ack, busy); end
    bus.wr_req = 1'b0;
    @(posedge clk);
    #1;
    wait_done(0, lat, rd_cnt, addr_err, excl_err, busy_we, busy_first);
    checks++; if (lat !== 651 || busy_first !== 1'b1) begin errors++; $display("[TB] FAIL sw_sweep: latency %0d busy %b expected 651 1", lat, busy_first); end
    checks++; if (ram[3] !== -8'sd5) begin errors++; $display("[TB] FAIL sw_ram: got %h expected fb", ram[3]); end
  endtask

  task automatic test_reset_mid_sweep();
    int seen;
    load_weights(0);
    load_pattern(DEF_PAT);
    @(negedge clk);
    start     = 1'b1;
    sync_mode = 1'b0;
    @(posedge clk);
    #1 start  = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ctrl: busy %b done %b rd %b expected 0 0 0", busy, done, bus.mem_rd); end
    checks++; if (neuros !== DEF_PAT) begin errors++; $display("[TB] FAIL mid_rst_neuros: got %h expected %h", neuros, DEF_PAT); end
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (700) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL mid_rst_no_done: got %0d active cycles expected 0", seen); end
    run_sweep(1'b0, 0);
    checks++; if (lat !== 651) begin errors++; $display("[TB] FAIL mid_rst_rerun_latency: got %0d expected 651", lat); end
    checks++; if (neuros !== 25'd0 || converged !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rerun: neuros %h conv %b expected 0 0", neuros, converged); end
  endtask

  initial begin
    start        = 1'b0;
    sync_mode    = 1'b0;
    init_load    = 1'b0;
    init_pattern = '0;
    fill_go      = 1'b0;
    fill_kind    = 0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    test_reset();
    test_zero_weights();
    test_diag();
    test_saturate();
    test_chain();
    test_write_during_sweep();
    test_start_with_write();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
